// File: rtl/expr2_pkg.sv
// Shared definitions for the two-level expression sweep checker.
// Holds the golden truth table, the sweep FSM state type and the res bit map.
package expr2_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned VEC_W   = 4;
  localparam int unsigned RES_W   = 6;
  localparam int unsigned CNT_W   = 5;

  // F = x'z + xy' + wx'y, indexed by {w,x,y,z}
  localparam logic [NUM_VEC-1:0] GOLDEN = 16'h3E3A;

  // res bit positions: {d2,d1,g2,g1,b2,b1}
  localparam int unsigned RES_B1 = 0;
  localparam int unsigned RES_B2 = 1;
  localparam int unsigned RES_G1 = 2;
  localparam int unsigned RES_G2 = 3;
  localparam int unsigned RES_D1 = 4;
  localparam int unsigned RES_D2 = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Every implementation under test realises the same F, so all res bits share one golden value.
  function automatic logic [RES_W-1:0] golden_res(input logic [VEC_W-1:0] v);
    return {RES_W{GOLDEN[v]}};
  endfunction

endpackage

// File: rtl/expr2_sweep_checker.sv
// Exhaustive sweep checker: drives all 16 {w,x,y,z} vectors to an external
// expression stage and compares its six result bits against the golden table.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, abort           begin a sweep (IDLE/DONE) / stop a running sweep
//   res[5:0]               results {d2,d1,g2,g1,b2,b1} from the expression stage
//   w, x, y, z             registered stimulus
//   busy, done, pass       sweep status
//   mismatch_cnt[4:0]      failing vectors (saturates at 16)
//   fail_mask[5:0]         sticky per-bit mismatch flags
//   first_fail_vec[3:0]    first failing vector, valid with first_fail_valid
module expr2_sweep_checker
  import expr2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] res,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic [5:0] fail_mask,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  state_e             state, state_nxt;
  logic [VEC_W-1:0]   vec, vec_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RES_W-1:0]   mask_nxt;
  logic [VEC_W-1:0]   ffv_nxt;
  logic               ffvalid_nxt;
  logic               busy_nxt, done_nxt, pass_nxt;
  logic [RES_W-1:0]   diff_c;

  assign {w, x, y, z} = vec;
  assign diff_c       = res ^ golden_res(vec);

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      vec              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      fail_mask        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_nxt;
      vec              <= vec_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      mismatch_cnt     <= cnt_nxt;
      fail_mask        <= mask_nxt;
      first_fail_vec   <= ffv_nxt;
      first_fail_valid <= ffvalid_nxt;
    end
  end

  // Next-state, vector stepping and comparison
  always_comb begin
    state_nxt   = state;
    vec_nxt     = vec;
    cnt_nxt     = mismatch_cnt;
    mask_nxt    = fail_mask;
    ffv_nxt     = first_fail_vec;
    ffvalid_nxt = first_fail_valid;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt   = ST_DRIVE;
          vec_nxt     = '0;
          cnt_nxt     = '0;
          mask_nxt    = '0;
          ffv_nxt     = '0;
          ffvalid_nxt = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          vec_nxt   = '0;
        end else begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // The current vector is scored even when abort arrives in this cycle.
        if (|diff_c) begin
          if (mismatch_cnt != CNT_W'(NUM_VEC)) cnt_nxt = mismatch_cnt + CNT_W'(1);
          mask_nxt = fail_mask | diff_c;
          if (!first_fail_valid) begin
            ffv_nxt     = vec;
            ffvalid_nxt = 1'b1;
          end
        end
        if (abort) begin
          state_nxt = ST_IDLE;
          vec_nxt   = '0;
        end else if (vec == VEC_W'(NUM_VEC - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRIVE;
          vec_nxt   = vec + VEC_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE);
    // done follows one cycle after entering DONE and drops as soon as a new start is taken.
    done_nxt = (state == ST_DONE) && (state_nxt == ST_DONE);
    pass_nxt = done_nxt && (cnt_nxt == '0);
  end

endmodule

// File: tb/tb_expr2_sweep_checker.sv
// Directed bench for expr2_sweep_checker with a behavioural expression stage
// whose results can be forced or corrupted per test.
module tb_expr2_sweep_checker;

  logic       clk, rst_n, start, abort;
  logic [5:0] res;
  logic       w, x, y, z, busy, done, pass;
  logic [4:0] mismatch_cnt;
  logic [5:0] fail_mask;
  logic [3:0] first_fail_vec;
  logic       first_fail_valid;

  int mode;        // 0 correct, 1 force 00, 2 force 3F, 3 g1 inverted on vec 10
  int n_chk  = 0;
  int n_pass = 0;
  int edges;

  expr2_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .res(res),
    .w(w), .x(x), .y(y), .z(z), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .fail_mask(fail_mask),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic f_ref(input logic [3:0] v);
    logic fw, fx, fy, fz;
    {fw, fx, fy, fz} = v;
    return (~fx & fz) | (fx & ~fy) | (fw & ~fx & fy);
  endfunction

  // Expression stage model
  always_comb begin
    res = {6{f_ref({w, x, y, z})}};
    case (mode)
      1:       res = 6'h00;
      2:       res = 6'h3F;
      3:       if ({w, x, y, z} == 4'hA) res = res ^ 6'h04;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start, optionally re-pulse it mid-sweep, and count edges until done.
  task automatic run_sweep(input int m, input int stray_at, output int n_edges);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'h1);
    check("done_dropped", 32'(done), 32'h0);
    n_edges = 0;
    while (!done && n_edges < 40) begin
      if (n_edges == stray_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_edges++;
    end
    check("sweep_edges", 32'(n_edges), 32'd33);
    check("busy_at_done", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    #12;
    check("rst_flags", 32'({w, x, y, z, busy, done, pass, first_fail_valid}), 32'h0);
    check("rst_cnt", 32'(mismatch_cnt), 32'h0);
    check("rst_mask", 32'(fail_mask), 32'h0);
    check("rst_ffv", 32'(first_fail_vec), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_sweep", 32'({busy, done}), 32'h0);

    // Clean sweep
    run_sweep(0, -1, edges);
    check("clean_pass", 32'(pass), 32'h1);
    check("clean_cnt", 32'(mismatch_cnt), 32'h0);
    check("clean_mask", 32'(fail_mask), 32'h0);
    check("clean_ffvalid", 32'(first_fail_valid), 32'h0);

    // Forced 00, restarted from DONE, stray start mid-sweep must be ignored
    run_sweep(1, 5, edges);
    check("zero_cnt", 32'(mismatch_cnt), 32'd9);
    check("zero_mask", 32'(fail_mask), 32'h3F);
    check("zero_ffv", 32'(first_fail_vec), 32'h1);
    check("zero_ffvalid", 32'(first_fail_valid), 32'h1);
    check("zero_pass", 32'(pass), 32'h0);

    // Forced 3F
    run_sweep(2, -1, edges);
    check("ones_cnt", 32'(mismatch_cnt), 32'd7);
    check("ones_mask", 32'(fail_mask), 32'h3F);
    check("ones_ffv", 32'(first_fail_vec), 32'h0);

    // Single corrupted bit
    run_sweep(3, -1, edges);
    check("g1_cnt", 32'(mismatch_cnt), 32'd1);
    check("g1_mask", 32'(fail_mask), 32'h04);
    check("g1_ffv", 32'(first_fail_vec), 32'hA);
    check("g1_pass", 32'(pass), 32'h0);

    // Abort on edge 10 (SAMPLE of vec 4), with start also high: abort wins
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_vec", 32'({w, x, y, z}), 32'h0);
    check("abort_cnt_held", 32'(mismatch_cnt), 32'd3);
    check("abort_ffv", 32'(first_fail_vec), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'({busy, done}), 32'h0);
    run_sweep(0, -1, edges);
    check("post_abort_pass", 32'(pass), 32'h1);
    check("post_abort_cnt", 32'(mismatch_cnt), 32'h0);

    // Asynchronous reset in the middle of a sweep
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while ({w, x, y, z} != 4'h7 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("reach_vec7", 32'({w, x, y, z}), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 32'({w, x, y, z, busy, done, pass, first_fail_valid}), 32'h0);
    check("mid_rst_cnt", 32'(mismatch_cnt), 32'h0);
    check("mid_rst_mask", 32'({fail_mask, first_fail_vec}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rel_no_sweep", 32'({busy, done}), 32'h0);

    // start and abort together in IDLE: start wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_start_wins", 32'(busy), 32'h1);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_drive", 32'(busy), 32'h0);

    run_sweep(0, -1, edges);
    check("final_pass", 32'(pass), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/expr2_sweep_checker.md
EXPR2_SWEEP_CHECKER -- requirements
Module: expr2_sweep_checker

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-005 abort  input  1  stops a running sweep; returns to IDLE.
REQ-006 res  input  6  results from the expression stage; bit order {d2,d1,g2,g1,b2,b1}.
REQ-007 w, x, y, z  output  1 each  registered stimulus to the expression stage.
REQ-008 busy  output  1  high while a sweep runs.
REQ-009 done  output  1  high from sweep completion until the next accepted start.
REQ-010 pass  output  1  valid when done; 1 iff mismatch_cnt == 0.
REQ-011 mismatch_cnt  output  5  number of vectors (0..16) with at least one wrong res bit.
REQ-012 fail_mask  output  6  sticky per-bit flag: res bit ever differed from golden.
REQ-013 first_fail_vec  output  4  {w,x,y,z} of the first failing vector; valid when first_fail_valid.
REQ-014 first_fail_valid  output  1  set on the first mismatch of the sweep.

Function
REQ-015 Golden function SHALL be F = x'z + xy' + wx'y, held as the 16-bit table GOLDEN = 16'h3E3A indexed by vec = {w,x,y,z}.
REQ-016 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-017 IDLE: start=1 -> DRIVE with vec=0; clear mismatch_cnt, fail_mask, first_fail_*; drop done.
REQ-018 DRIVE (1 cycle): {w,x,y,z} already equal vec; -> SAMPLE (one settle cycle).
REQ-019 SAMPLE (1 cycle): compare each res bit with GOLDEN[vec]; on any difference, increment mismatch_cnt and OR the difference into fail_mask.
REQ-020 SAMPLE: on the first mismatch of the sweep, load first_fail_vec=vec and set first_fail_valid.
REQ-021 SAMPLE with vec<15: vec increments, -> DRIVE; vec==15: -> DONE, no wrap.
REQ-022 Vector registers SHALL update on the SAMPLE->DRIVE edge, so res is stable for a full DRIVE cycle before sampling.
REQ-023 Sweep length: 32 cycles; done rises on the 33rd rising edge after the edge that samples start.
REQ-024 DONE: done=1, busy=0; results held; start=1 -> behaves as IDLE start (REQ-017).
REQ-025 busy SHALL be 1 in DRIVE and SAMPLE only.
REQ-026 start during DRIVE/SAMPLE SHALL be ignored.
REQ-027 abort in DRIVE/SAMPLE SHALL -> IDLE next cycle, with done=0, vec=0, and counters held.
REQ-028 abort and start in the same cycle: abort wins in DRIVE/SAMPLE; start wins in IDLE/DONE.
REQ-029 Abort on the final SAMPLE SHALL still count that vector, then -> IDLE (not DONE).
REQ-030 mismatch_cnt SHALL saturate at 16; 5 bits, no overflow.

Reset
REQ-031 rst_n low SHALL force IDLE, vec=0, w=x=y=z=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_mask=0, first_fail_vec=0, first_fail_valid=0.
REQ-032 Reset mid-sweep SHALL discard all progress immediately (asynchronous).
REQ-033 Release SHALL take effect on the first rising clk edge after rst_n goes high; no sweep starts without start.

Structure
REQ-034 Shared package expr2_pkg SHALL hold GOLDEN (16'h3E3A), the state enum, the NUM_VEC=16 constant, and the res bit-index constants.
REQ-035 No sub-module is needed; the vector counter and comparator are inline. The expression stage is instantiated by the integration top, not inside this block.

Verification
REQ-036 Correct expression stage attached, start pulse -> done after 33 edges, pass=1, mismatch_cnt=0, fail_mask=0, first_fail_valid=0.
REQ-037 Forced res=6'h00 -> mismatch_cnt=9, fail_mask=6'h3F, first_fail_vec=4'h1, pass=0.
REQ-038 Forced res=6'h3F -> mismatch_cnt=7, first_fail_vec=4'h0, fail_mask=6'h3F.
REQ-039 Only bit g1 inverted on vec 10 -> mismatch_cnt=1, fail_mask=6'h04, first_fail_vec=4'hA.
REQ-040 Abort in cycle 10 of a sweep -> IDLE next cycle, done=0, busy=0, and a new start gives a full clean sweep.
REQ-041 rst_n pulled low at vec 7 -> all outputs at reset values immediately; start ignored while busy and accepted again from DONE.
